cpu_control: RTL
================

CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 Parameters: none; instruction width fixed at 16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_instr  input  16  instruction word offered for capture.
REQ-005 load  input  1  capture in_instr into IR (accepted only in WAIT).
REQ-006 s  input  1  start execution of IR (sampled only in WAIT).
REQ-007 Z_out  input  3  datapath status: [0]=Z, [1]=N, [2]=V.
REQ-008 w  output  1  high only in WAIT (ready for load/s).
REQ-009 vsel  output  2  datapath write mux: 0=C, 1=PC, 2=sximm8, 3=mdata.
REQ-010 asel, bsel  output  1 each  A-zero select / B-sximm5 select.
REQ-011 ALUop  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT-B.
REQ-012 loada, loadb, loadc, loads, write  output  1 each  datapath strobes.
REQ-013 readnum, writenum  output  3 each  register indices.
REQ-014 shift  output  2  IR[4:3] in GET_B and ALU states, else 00.
REQ-015 sximm8, sximm5  output  16 each  sign extensions of IR[7:0], IR[4:0].
REQ-016 N, V, Z  output  1 each  Z_out[1], Z_out[2], Z_out[0] passthrough.

Function
REQ-017 IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], Rm=IR[2:0].
REQ-018 States: WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM; outputs are Moore, decoded from state and IR.
REQ-019 WAIT: load=1 captures IR at edge; s=1 -> DECODE; load and s together: IR captured, DECODE uses new IR.
REQ-020 DECODE: 110/10 -> WRITE_IMM; 110/00 -> GET_B; 101/00,01,10 -> GET_A; 101/11 -> GET_B; any other -> WAIT with no strobe asserted.
REQ-021 GET_A: readnum=Rn, loada=1 -> GET_B.
REQ-022 GET_B: readnum=Rm, loadb=1 -> ALU.
REQ-023 ALU: bsel=0; asel=1 for MOV-reg and MVN, else 0; ALUop=00 for MOV-reg, else op; CMP asserts loads only -> WAIT; others assert loadc -> WRITE_REG.
REQ-024 WRITE_REG: writenum=Rd, vsel=0, write=1 -> WAIT; WRITE_IMM: writenum=Rn, vsel=2, write=1 -> WAIT.
REQ-025 Latency from s sampled: MOV-imm 2 cycles, MOV-reg/MVN 4, CMP 4, ADD/AND 5 before w returns high.
REQ-026 Outside the state that needs it, every strobe is 0, readnum/writenum are 000, vsel is 00.
REQ-027 load and s outside WAIT are ignored; IR is stable for a whole instruction.

Reset
REQ-028 reset=1 forces WAIT immediately regardless of clk, clears IR to 0; w=1, all strobes 0 while asserted.
REQ-029 Reset mid-instruction aborts it; no write follows release.

Configuration
REQ-030 CPU_CONTROL_MVN_EN defined: MVN executes per REQ-020/023.
REQ-031 CPU_CONTROL_MVN_EN undefined: 101/11 is illegal, DECODE -> WAIT, no register written.

Structure
REQ-032 Package cpu_pkg holds the state enum, opcode/op constants, and vsel/ALUop encodings.
REQ-033 Combinational sub-module ir_decode provides field extraction and sign extension.

Verification
REQ-034 Reset mid-ADD in GET_B -> WAIT same cycle, w=1, write never asserted.
REQ-035 load 0xD007, s=1 -> DECODE, WRITE_IMM with writenum=0, vsel=2, sximm8=0x0007, write=1, then WAIT.
REQ-036 load 0xA148 (ADD R2,R1,R0 LSL#1) -> readnum 1 (loada), readnum 0 with shift=01 (loadb), loadc, writenum=2 write; w high at cycle 5.
REQ-037 load 0xA900 (CMP R1,R0) -> loads=1 in ALU, loadc=0, write never 1.
REQ-038 load 0xB860 (MVN R3,R0) -> with macro: asel=1, ALUop=11, writenum=3; without: back to WAIT after DECODE, write=0.
REQ-039 load 0xD0F0 -> sximm8=0xFFF0; load pulsed outside WAIT -> IR unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_control block: controller state encoding,
// instruction opcode/op values, datapath mux and ALU encodings, and the
// sign-extension helpers used by the instruction field decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_ALU       = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_WRITE_IMM = 3'd6
    } state_t;

    // Opcode field IR[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field IR[12:11] under OPC_MOV
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    // op field IR[12:11] under OPC_ALU
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    // Register-file write mux
    localparam logic [1:0] VSEL_C      = 2'd0;
    localparam logic [1:0] VSEL_PC     = 2'd1;
    localparam logic [1:0] VSEL_SXIMM8 = 2'd2;
    localparam logic [1:0] VSEL_MDATA  = 2'd3;

    // ALU operation
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    function automatic logic [15:0] sext8(input logic [7:0] imm);
        return {{8{imm[7]}}, imm};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational instruction-register field extraction.
// Ports:
//   ir          - 16-bit instruction register contents
//   opcode, op  - IR[15:13], IR[12:11]
//   rn, rd, rm  - register indices IR[10:8], IR[7:5], IR[2:0]
//   shift_field - IR[4:3] shifter control
//   sximm8      - IR[7:0] sign-extended to 16 bits
//   sximm5      - IR[4:0] sign-extended to 16 bits
module ir_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  shift_field,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    assign opcode      = ir[15:13];
    assign op          = ir[12:11];
    assign rn          = ir[10:8];
    assign rd          = ir[7:5];
    assign rm          = ir[2:0];
    assign shift_field = ir[4:3];
    assign sximm8      = sext8(ir[7:0]);
    assign sximm5      = sext5(ir[4:0]);

endmodule

// File: rtl/cpu_control.sv
// Instruction register and multicycle Moore controller for the simple CPU
// datapath. An instruction is captured in WAIT, then sequenced through
// DECODE / GET_A / GET_B / ALU / WRITE_REG or WRITE_IMM, driving the
// datapath strobes and register indices from the current state and IR.
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   in_instr, load, s     - instruction word, capture strobe, start (WAIT only)
//   Z_out                 - datapath status {V, N, Z}
//   w                     - high only while waiting for a new instruction
//   vsel, asel, bsel      - datapath mux selects
//   ALUop, shift          - ALU operation and shifter control
//   loada/b/c, loads      - pipeline register / status strobes
//   write, readnum/writenum - register-file controls
//   sximm8, sximm5        - sign-extended immediates from IR
//   N, V, Z               - status passthrough
// Build option: define CPU_CONTROL_MVN_EN to execute MVN (101/11); without
// it that encoding is treated as illegal and returns to WAIT after DECODE.
module cpu_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_instr,
    input  logic        load,
    input  logic        s,
    input  logic [2:0]  Z_out,
    output logic        w,
    output logic [1:0]  vsel,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        N,
    output logic        V,
    output logic        Z
);

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] ir_r;

    logic [2:0]  opcode_s;
    logic [1:0]  op_s;
    logic [2:0]  rn_s;
    logic [2:0]  rd_s;
    logic [2:0]  rm_s;
    logic [1:0]  shift_field_s;
    logic        is_mov_reg_s;
    logic        is_mvn_s;
    logic        is_cmp_s;

    ir_decode u_ir_decode (
        .ir          (ir_r),
        .opcode      (opcode_s),
        .op          (op_s),
        .rn          (rn_s),
        .rd          (rd_s),
        .rm          (rm_s),
        .shift_field (shift_field_s),
        .sximm8      (sximm8),
        .sximm5      (sximm5)
    );

    assign N = Z_out[1];
    assign V = Z_out[2];
    assign Z = Z_out[0];

    // The only MOV-opcode instruction that reaches the ALU is MOV-reg.
    assign is_mov_reg_s = (opcode_s == OPC_MOV);
    assign is_mvn_s     = (opcode_s == OPC_ALU) && (op_s == OP_MVN);
    assign is_cmp_s     = (opcode_s == OPC_ALU) && (op_s == OP_CMP);

    // Instruction register: captured only while idle, so it holds for a whole instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_r <= 16'h0000;
        end else if ((state_r == ST_WAIT) && load) begin
            ir_r <= in_instr;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore output decode from state and IR.
    always_comb begin
        state_next_s = state_r;
        w            = 1'b0;
        vsel         = VSEL_C;
        asel         = 1'b0;
        bsel         = 1'b0;
        ALUop        = ALU_ADD;
        loada        = 1'b0;
        loadb        = 1'b0;
        loadc        = 1'b0;
        loads        = 1'b0;
        write        = 1'b0;
        readnum      = 3'b000;
        writenum     = 3'b000;
        shift        = 2'b00;

        case (state_r)
            ST_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DECODE: begin
                if ((opcode_s == OPC_MOV) && (op_s == OP_MOV_IMM)) begin
                    state_next_s = ST_WRITE_IMM;
                end else if ((opcode_s == OPC_MOV) && (op_s == OP_MOV_REG)) begin
                    state_next_s = ST_GET_B;
                end else if ((opcode_s == OPC_ALU) && (op_s != OP_MVN)) begin
                    state_next_s = ST_GET_A;
                end else if (is_mvn_s) begin
`ifdef CPU_CONTROL_MVN_EN
                    state_next_s = ST_GET_B;
`else
                    state_next_s = ST_WAIT;
`endif
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_GET_A: begin
                readnum      = rn_s;
                loada        = 1'b1;
                state_next_s = ST_GET_B;
            end
            ST_GET_B: begin
                readnum      = rm_s;
                loadb        = 1'b1;
                shift        = shift_field_s;
                state_next_s = ST_ALU;
            end
            ST_ALU: begin
                shift = shift_field_s;
                asel  = is_mov_reg_s || is_mvn_s;
                if (is_mov_reg_s) begin
                    ALUop = ALU_ADD;
                end else begin
                    ALUop = op_s;
                end
                // CMP only updates status flags; nothing is written back.
                if (is_cmp_s) begin
                    loads        = 1'b1;
                    state_next_s = ST_WAIT;
                end else begin
                    loadc        = 1'b1;
                    state_next_s = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: begin
                writenum     = rd_s;
                vsel         = VSEL_C;
                write        = 1'b1;
                state_next_s = ST_WAIT;
            end
            ST_WRITE_IMM: begin
                writenum     = rn_s;
                vsel         = VSEL_SXIMM8;
                write        = 1'b1;
                state_next_s = ST_WAIT;
            end
            default: begin
                state_next_s = ST_WAIT;
            end
        endcase
    end

endmodule
